// File: rtl/jpeg_bit_packer_pkg.sv
// Shared types and constants for the JPEG entropy bit packer.
// Code words carry {len,data}; BURST follows the encoder pipeline depth.
package jpeg_bit_packer_pkg;

    localparam int CODE_W = 38;
    localparam int MAX_CODE_LEN = 32;
    localparam int DCT_TH = 28;
    localparam int BURST_FREE = DCT_TH + 1 + 5;
    localparam int CODE_FIFO_DEPTH = 64;

    localparam logic [7:0] JPEG_STUFF_BYTE = 8'h00;
    localparam logic [7:0] JPEG_MARKER_BYTE = 8'hFF;

    typedef struct packed {
        logic [5:0]  len;
        logic [31:0] data;
    } code_t;

    typedef enum logic [1:0] {
        RUN,
        PAD,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [5:0] clamp_len(input logic [5:0] l);
        return (l > 6'(MAX_CODE_LEN)) ? 6'(MAX_CODE_LEN) : l;
    endfunction

endpackage

// File: rtl/packer_code_fifo.sv
// Code FIFO with a registered head entry; a write into an empty FIFO
// bypasses the RAM so the head is usable on the very next cycle.
module packer_code_fifo
    import jpeg_bit_packer_pkg::*;
#(
    parameter int DEPTH = CODE_FIFO_DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  code_t       wdata,
    input  logic        pop,
    output code_t       rdata,
    output logic        empty,
    output logic        full,
    output logic [AW:0] free
);

    code_t       mem [DEPTH];
    code_t       q;
    logic        q_valid;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic [AW:0] mem_cnt;
    logic        do_push;
    logic        do_pop;
    logic        refill;
    logic        bypass;
    logic        mem_we;

    // count covers the head register as well as the RAM contents
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = !q_valid;
    assign free    = (AW+1)'(DEPTH) - count;
    assign rdata   = q;
    assign do_push = push && !full;
    assign do_pop  = pop && q_valid;
    assign refill  = !q_valid || do_pop;
    assign mem_cnt = count - (AW+1)'(q_valid);
    assign bypass  = refill && (mem_cnt == '0) && do_push;
    assign mem_we  = do_push && !bypass;

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            if (mem_we) wr_ptr <= wr_ptr + AW'(1);
            if (refill) begin
                if (mem_cnt != '0) begin
                    q       <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + AW'(1);
                    q_valid <= 1'b1;
                end else begin
                    q       <= wdata;
                    q_valid <= do_push;
                end
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs variable-length codes MSB-first into bytes with 0xFF stuffing
// and end-of-frame 1-padding, behind a burst-absorbing code FIFO.
module jpeg_bit_packer
    import jpeg_bit_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = CODE_FIFO_DEPTH,
    parameter int BURST = BURST_FREE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  in_len,
    input  logic [31:0] in_data,
    output logic        room,
    input  logic        flush,
    output logic        flush_done,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    code_t       wcode;
    code_t       head;
    logic        push;
    logic        empty;
    logic        full;
    logic        load;
    logic [AW:0] free;

    state_t      state;
    state_t      state_n;
    logic        allow_load;
    logic        do_pad;
    logic        flush_pend;
    logic        stuff;
    logic [63:0] acc;
    logic [63:0] acc_n;
    logic [63:0] acc_sh;
    logic [6:0]  fill;
    logic [6:0]  fill_n;
    logic [6:0]  head_len;
    logic [6:0]  pad_len;
    logic [7:0]  out_byte;
    logic        out_free;
    logic        take;

    assign push  = (in_len != 6'd0);
    assign wcode = '{len: clamp_len(in_len), data: in_data};

    packer_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wcode),
        .pop   (load),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .free  (free)
    );

    assign head_len = {1'b0, head.len};
    assign pad_len  = 7'd8 - {4'd0, fill[2:0]};
    assign load     = allow_load && !empty && (fill + head_len <= 7'd64);
    assign out_free = !o_valid || o_ready;
    assign take     = out_free && !stuff && (fill >= 7'd8);
    assign acc_sh   = acc >> (fill - 7'd8);
    assign out_byte = acc_sh[7:0];
    assign flush_done = (state == DONE);

    always_comb begin
        state_n    = state;
        allow_load = 1'b0;
        do_pad     = 1'b0;
        unique case (state)
            RUN: begin
                allow_load = 1'b1;
                if (flush_pend && empty)
                    state_n = (fill[2:0] != 3'd0) ? PAD : DRAIN;
            end
            PAD: begin
                do_pad  = 1'b1;
                state_n = DRAIN;
            end
            DRAIN: begin
                if (fill == 7'd0 && !stuff && !o_valid) state_n = DONE;
            end
            DONE: state_n = RUN;
        endcase
    end

    // emit uses the pre-load acc/fill; the load shifts in below the remaining bits
    always_comb begin
        acc_n  = acc;
        fill_n = fill;
        if (take) fill_n = fill - 7'd8;
        if (load) begin
            acc_n  = (acc << head.len) |
                     (64'(head.data) & ((64'd1 << head.len) - 64'd1));
            fill_n = fill_n + head_len;
        end else if (do_pad) begin
            acc_n  = (acc << pad_len) | ((64'd1 << pad_len) - 64'd1);
            fill_n = fill_n + pad_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            fill       <= '0;
            stuff      <= 1'b0;
            flush_pend <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            ovf        <= 1'b0;
            room       <= 1'b0;
        end else begin
            acc  <= acc_n;
            fill <= fill_n;
            room <= (free >= (AW+1)'(BURST));
            if (push && full) ovf <= 1'b1;
            if (flush)              flush_pend <= 1'b1;
            else if (state == DONE) flush_pend <= 1'b0;
            if (out_free) begin
                if (stuff) begin
                    o_data  <= JPEG_STUFF_BYTE;
                    o_valid <= 1'b1;
                    stuff   <= 1'b0;
                end else if (fill >= 7'd8) begin
                    o_data  <= out_byte;
                    o_valid <= 1'b1;
                    stuff   <= (out_byte == JPEG_MARKER_BYTE);
                end else begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule
